// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Instruction fetch PC generator. Issues one fetch request per cycle to the
//   instruction memory, advances the PC sequentially by INC on each accepted
//   request, and redirects on flush/branch. A redirect that arrives while a
//   request is waiting for its ack is parked in a one-entry pending register
//   and applied on the ack edge.
//
// Parameters
//   ADDR_W    : width of the PC and all address ports
//   RESET_VEC : PC value loaded by reset
//   INC       : sequential increment (power of two); also the redirect alignment
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   stall           : hold; a request acked while stall=1 parks the unit in HOLD
//   flush, flush_pc : highest-priority redirect and its target
//   branch_valid,
//   branch_target   : branch redirect and its target
//   imem_req        : fetch request (high in REQ only)
//   imem_addr       : fetch address, always equal to pc
//   imem_ack        : memory accepted the request this cycle
//   pc              : current fetch PC
//   ce              : chip enable, low in reset and IDLE
//   fetch_done      : imem_req & imem_ack
//   misalign        : one-cycle pulse after a captured redirect target had
//                     nonzero low alignment bits
//
// state | meaning
// IDLE  | just out of reset, no request; next edge starts fetching
// REQ   | request outstanding at pc, waiting for ack
// HOLD  | stalled after an accepted fetch, no request
module pc_fetch_unit #(
  parameter int                  ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]   RESET_VEC = '0,
  parameter int                  INC       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              fetch_done,
  output logic              misalign
);

  localparam int                ALIGN_B  = $clog2(INC);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << ALIGN_B) - 64'd1);
  localparam logic [ADDR_W-1:0] INC_V    = ADDR_W'(INC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic              pend_flush_q, pend_flush_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              misalign_q, misalign_d;

  logic [ADDR_W-1:0] flush_al, branch_al;
  logic              flush_mis, branch_mis;
  logic              pend_is_flush;

  assign flush_al      = flush_pc & ~LOW_MASK;
  assign branch_al     = branch_target & ~LOW_MASK;
  assign flush_mis     = |(flush_pc & LOW_MASK);
  assign branch_mis    = |(branch_target & LOW_MASK);
  assign pend_is_flush = pend_valid_q & pend_flush_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_flush_d = pend_flush_q;
    pend_addr_d  = pend_addr_q;
    misalign_d   = 1'b0;
    imem_req     = 1'b0;
    ce           = 1'b1;

    case (state_q)
      S_IDLE: begin
        ce      = 1'b0;
        state_d = S_REQ;
      end

      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          pend_valid_d = 1'b0;
          if (flush) begin
            pc_d       = flush_al;
            misalign_d = flush_mis;
          end else if (pend_is_flush) begin
            pc_d = pend_addr_q;
          end else if (branch_valid) begin
            pc_d       = branch_al;
            misalign_d = branch_mis;
          end else if (pend_valid_q) begin
            pc_d = pend_addr_q;
          end else begin
            pc_d = pc_q + INC_V;
          end
          state_d = stall ? S_HOLD : S_REQ;
        end else if (flush) begin
          // a newer flush replaces whatever is parked
          pend_valid_d = 1'b1;
          pend_flush_d = 1'b1;
          pend_addr_d  = flush_al;
          misalign_d   = flush_mis;
        end else if (branch_valid && !pend_is_flush) begin
          pend_valid_d = 1'b1;
          pend_flush_d = 1'b0;
          pend_addr_d  = branch_al;
          misalign_d   = branch_mis;
        end
      end

      S_HOLD: begin
        // pending is always empty here: it is cleared on the ack edge that entered HOLD
        if (flush) begin
          pc_d       = flush_al;
          misalign_d = flush_mis;
        end else if (branch_valid) begin
          pc_d       = branch_al;
          misalign_d = branch_mis;
        end
        if (!stall) state_d = S_REQ;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_VEC;
      pend_valid_q <= 1'b0;
      pend_flush_q <= 1'b0;
      pend_addr_q  <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_flush_q <= pend_flush_d;
      pend_addr_q  <= pend_addr_d;
      misalign_q   <= misalign_d;
    end
  end

  assign pc         = pc_q;
  assign imem_addr  = pc_q;
  assign fetch_done = imem_req & imem_ack;
  assign misalign   = misalign_q;

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the width of every address port and of the PC.
REQ-002 Parameter RESET_VEC, default 32'h00000000, SHALL set the PC value loaded by reset.
REQ-003 Parameter INC, default 4, SHALL set the sequential increment, a power of two ≥1; ALIGN_B = log2(INC).
REQ-004 clk  in  1  rising-edge clock; all state SHALL update only on this edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 stall  in  1  pipeline hold; suppresses new fetch requests.
REQ-007 flush  in  1  exception/flush redirect strobe.
REQ-008 flush_pc  in  ADDR_W  flush target.
REQ-009 branch_valid  in  1  branch/jump redirect strobe.
REQ-010 branch_target  in  ADDR_W  branch target.
REQ-011 imem_req  out  1  fetch request to instruction memory.
REQ-012 imem_addr  out  ADDR_W  fetch address; always equals pc.
REQ-013 imem_ack  in  1  memory accepted the request this cycle.
REQ-014 pc  out  ADDR_W  current fetch PC.
REQ-015 ce  out  1  chip enable; 0 in reset and IDLE, 1 otherwise.
REQ-016 fetch_done  out  1  combinational, = imem_req & imem_ack.
REQ-017 misalign  out  1  one-cycle pulse: a redirect target had nonzero low ALIGN_B bits.

Function
REQ-018 States SHALL be IDLE, REQ, HOLD; IDLE is entered only via reset.
REQ-019 IDLE: imem_req=0, ce=0; next edge with rst=0 -> REQ (ce=1, imem_req=1, pc=RESET_VEC), giving one cycle of latency from reset release to the first request.
REQ-020 REQ: imem_req=1; pc/imem_addr SHALL stay stable until the ack edge; the request is never withdrawn without ack except by rst.
REQ-021 REQ ack edge: pc <= next_pc; state <= HOLD if stall=1, else REQ; back-to-back fetches SHALL sustain one per cycle while ack=1 and stall=0.
REQ-022 next_pc priority: flush (flush_pc) > pending flush > branch_valid (branch_target) > pending branch > pc+INC.
REQ-023 A redirect in REQ with imem_ack=0 SHALL be captured in a one-entry pending register; a flush overwrites a pending branch, and a branch never overwrites a pending flush.
REQ-024 The pending register SHALL be consumed and cleared on the next ack edge.
REQ-025 HOLD: imem_req=0, pc held; flush/branch_valid in HOLD SHALL load pc directly with the same priority; leave HOLD for REQ on the first edge with stall=0.
REQ-026 Every redirect target SHALL have its low ALIGN_B bits forced to 0 before use; misalign SHALL pulse on the cycle after capture when any dropped bit was 1.
REQ-027 pc+INC SHALL wrap modulo 2^ADDR_W with no flag.
REQ-028 stall=1 in REQ without ack SHALL NOT drop imem_req; stall takes effect at the ack edge.

Reset
REQ-029 rst=1 at an edge SHALL force state=IDLE, pc=RESET_VEC, ce=0, imem_req=0, pending cleared, misalign=0, overriding all other inputs, including mid-request.

Verification
REQ-030 rst 2 cycles, then ack tied 1 -> ce=0 for one cycle after release, then imem_addr 0x0,0x4,0x8,... one per cycle.
REQ-031 pc=0x100 in REQ, ack=0 for 3 cycles, branch_valid=1 with 0x200 in cycle 1 -> addr held at 0x100; after the ack, pc=0x200.
REQ-032 Same cycle flush (flush_pc=0x80) and branch_valid (0x300) at an ack edge -> pc=0x80.
REQ-033 ack with stall=1 at pc=0x10 -> imem_req=0, pc=0x14 held while stall=1; req reasserts one edge after stall=0.
REQ-034 Branch target 0x203 -> pc=0x200, misalign pulses for one cycle; ADDR_W=16 at pc=0xFFFC with ack -> pc=0x0000.
REQ-035 rst asserted while in REQ with a pending flush -> next cycle imem_req=0, pc=RESET_VEC, and the pending flush is lost.
